// File: rtl/knn_vote_if.sv
// rtl/knn_vote_if.sv - handshake and data bundle between distance sorter, knn_vote and its consumer
interface knn_vote_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] distance_in [N];
    logic [W-1:0] type_in     [N];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] class_out;
    logic [W-1:0] votes_out;
    logic [W-1:0] dist_out;
    logic         no_vote;

    // Upstream sorter plus downstream consumer side
    modport master (
        output in_valid, distance_in, type_in, out_ready,
        input  in_ready, out_valid, class_out, votes_out, dist_out, no_vote
    );

    // Classifier side
    modport slave (
        input  in_valid, distance_in, type_in, out_ready,
        output in_ready, out_valid, class_out, votes_out, dist_out, no_vote
    );
endinterface

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - sequential K-nearest-neighbour majority vote with nearest-first tie-break
module knn_vote #(
    parameter int N = 8,
    parameter int W = 16,
    parameter int K = 3,
    parameter int C = 4
) (
    input  logic      clk,
    input  logic      rst,
    knn_vote_if.slave bus
);
    localparam int CW = $clog2(K + 1);
    localparam int FW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t        state_q;

    // Snapshot of the K nearest entries taken on the accept edge
    logic [W-1:0]  ent_dist_q [K];
    logic [W-1:0]  ent_type_q [K];

    // Per-class vote count, sorted position of first member and its distance
    logic [CW-1:0] cnt_q      [C];
    logic [FW-1:0] first_q    [C];
    logic [W-1:0]  fdist_q    [C];

    logic [FW-1:0] idx_q;
    logic [SW-1:0] cls_q;

    logic [CW-1:0] best_cnt_q;
    logic [FW-1:0] best_first_q;
    logic [SW-1:0] best_cls_q;
    logic [W-1:0]  best_dist_q;

    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  class_out_q;
    logic [W-1:0]  votes_out_q;
    logic [W-1:0]  dist_out_q;
    logic          no_vote_q;

    logic [W-1:0]  cur_type;
    logic          cur_legal;
    logic [SW-1:0] cur_cls;

    logic          take;
    logic [CW-1:0] best_cnt_d;
    logic [FW-1:0] best_first_d;
    logic [SW-1:0] best_cls_d;
    logic [W-1:0]  best_dist_d;

    logic          unused_tail;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.class_out = class_out_q;
    assign bus.votes_out = votes_out_q;
    assign bus.dist_out  = dist_out_q;
    assign bus.no_vote   = no_vote_q;

    // Decode the entry being counted this cycle; labels compare at full width
    always_comb begin
        cur_type  = ent_type_q[idx_q];
        cur_legal = (cur_type < W'(C));
        cur_cls   = cur_type[SW-1:0];
    end

    // Running best while scanning classes; later class wins ties only if its first member is nearer
    always_comb begin
        take = (cnt_q[cls_q] > best_cnt_q) ||
               ((cnt_q[cls_q] == best_cnt_q) && (cnt_q[cls_q] != '0) &&
                (first_q[cls_q] < best_first_q));
        best_cnt_d   = best_cnt_q;
        best_first_d = best_first_q;
        best_cls_d   = best_cls_q;
        best_dist_d  = best_dist_q;
        if (take) begin
            best_cnt_d   = cnt_q[cls_q];
            best_first_d = first_q[cls_q];
            best_cls_d   = cls_q;
            best_dist_d  = fdist_q[cls_q];
        end
    end

    // Entries beyond the K voters are never looked at
    always_comb begin
        unused_tail = 1'b0;
        for (int i = K; i < N; i++) begin
            unused_tail = unused_tail ^ (^bus.distance_in[i]) ^ (^bus.type_in[i]);
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            class_out_q  <= '0;
            votes_out_q  <= '0;
            dist_out_q   <= '0;
            no_vote_q    <= 1'b0;
            idx_q        <= '0;
            cls_q        <= '0;
            best_cnt_q   <= '0;
            best_first_q <= '0;
            best_cls_q   <= '0;
            best_dist_q  <= '0;
            for (int c = 0; c < C; c++) begin
                cnt_q[c]   <= '0;
                first_q[c] <= '0;
                fdist_q[c] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                ent_dist_q[i] <= '0;
                ent_type_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        for (int i = 0; i < K; i++) begin
                            ent_dist_q[i] <= bus.distance_in[i];
                            ent_type_q[i] <= bus.type_in[i];
                        end
                        for (int c = 0; c < C; c++) begin
                            cnt_q[c]   <= '0;
                            first_q[c] <= '0;
                            fdist_q[c] <= '0;
                        end
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (cur_legal) begin
                        cnt_q[cur_cls] <= cnt_q[cur_cls] + CW'(1);
                        if (cnt_q[cur_cls] == '0) begin
                            first_q[cur_cls] <= idx_q;
                            fdist_q[cur_cls] <= ent_dist_q[idx_q];
                        end
                    end
                    if (idx_q == FW'(K - 1)) begin
                        cls_q        <= '0;
                        best_cnt_q   <= '0;
                        best_first_q <= '0;
                        best_cls_q   <= '0;
                        best_dist_q  <= '0;
                        state_q      <= S_DECIDE;
                    end else begin
                        idx_q <= idx_q + FW'(1);
                    end
                end
                S_DECIDE: begin
                    best_cnt_q   <= best_cnt_d;
                    best_first_q <= best_first_d;
                    best_cls_q   <= best_cls_d;
                    best_dist_q  <= best_dist_d;
                    if (cls_q == SW'(C - 1)) begin
                        if (best_cnt_d == '0) begin
                            class_out_q <= '0;
                            votes_out_q <= '0;
                            dist_out_q  <= '0;
                            no_vote_q   <= 1'b1;
                        end else begin
                            class_out_q <= W'(best_cls_d);
                            votes_out_q <= W'(best_cnt_d);
                            dist_out_q  <= best_dist_d;
                            no_vote_q   <= 1'b0;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cls_q <= cls_q + SW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - self-checking bench for knn_vote
module tb_knn_vote;
    localparam int N = 8;
    localparam int W = 16;
    localparam int K = 3;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knn_vote_if #(.N(N), .W(W)) bus ();

    knn_vote #(.N(N), .W(W), .K(K), .C(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] tv [N];
    logic [W-1:0] dv [N];
    logic [W-1:0] obs_c, obs_v, obs_d;
    logic         obs_nv;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: score each class by votes first, then by how early its nearest member sits
    task automatic model(output logic [W-1:0] c_o, output logic [W-1:0] v_o,
                         output logic [W-1:0] d_o, output logic nv_o);
        int cnt [C];
        int first [C];
        int best_score;
        int score;
        for (int c = 0; c < C; c++) begin
            cnt[c]   = 0;
            first[c] = 0;
        end
        for (int i = 0; i < K; i++) begin
            if (int'(tv[i]) < C) begin
                if (cnt[tv[i]] == 0) first[tv[i]] = i;
                cnt[tv[i]]++;
            end
        end
        best_score = -1;
        c_o = '0; v_o = '0; d_o = '0;
        for (int c = 0; c < C; c++) begin
            if (cnt[c] > 0) begin
                score = cnt[c] * (K + 1) + (K - first[c]);
                if (score > best_score) begin
                    best_score = score;
                    c_o = W'(c);
                    v_o = W'(cnt[c]);
                    d_o = dv[first[c]];
                end
            end
        end
        nv_o = (best_score < 0);
    endtask

    task automatic rand_dists();
        dv[0] = W'($urandom_range(0, 20));
        for (int i = 1; i < N; i++) dv[i] = dv[i-1] + W'($urandom_range(0, 20));
    endtask

    task automatic ack(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".ack_out_valid"}, W'(bus.out_valid), W'(0));
        check({tag, ".ack_in_ready"}, W'(bus.in_ready), W'(1));
    endtask

    // Present tv/dv, wait for the result, compare against the model; always returns on a negedge
    task automatic run_job(input string tag, input bit do_ack);
        logic [W-1:0] ec, ev, ed;
        logic         en;
        int           w;
        int           lat;
        model(ec, ev, ed, en);
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.type_in[i]     = tv[i];
            bus.distance_in[i] = dv[i];
        end
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".accept_ready"}, W'(bus.in_ready), W'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.type_in[i]     = W'($urandom);
            bus.distance_in[i] = W'($urandom);
        end
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            check({tag, ".busy_in_ready"}, W'(bus.in_ready), W'(0));
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, W'(lat), W'(K + C + 1));
        obs_c  = bus.class_out;
        obs_v  = bus.votes_out;
        obs_d  = bus.dist_out;
        obs_nv = bus.no_vote;
        check({tag, ".class"}, obs_c, ec);
        check({tag, ".votes"}, obs_v, ev);
        check({tag, ".dist"}, obs_d, ed);
        check({tag, ".no_vote"}, W'(obs_nv), W'(en));
        if (do_ack) ack(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.type_in[i]     = '0;
            bus.distance_in[i] = '0;
            tv[i]              = '0;
            dv[i]              = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.in_ready", W'(bus.in_ready), W'(1));
        check("reset.out_valid", W'(bus.out_valid), W'(0));
        check("reset.class", bus.class_out, W'(0));
        check("reset.votes", bus.votes_out, W'(0));
        check("reset.dist", bus.dist_out, W'(0));
        check("reset.no_vote", W'(bus.no_vote), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // Clear majority
        rand_dists();
        tv[0] = 2; tv[1] = 1; tv[2] = 2; dv[0] = 5; dv[1] = 9; dv[2] = 12;
        for (int i = 3; i < N; i++) begin
            tv[i] = W'($urandom_range(0, C - 1));
            dv[i] = dv[i-1] + W'($urandom_range(0, 20));
        end
        run_job("majority", 1'b1);
        check("majority.class_const", obs_c, W'(2));
        check("majority.votes_const", obs_v, W'(2));
        check("majority.dist_const", obs_d, W'(5));

        // Three-way tie, nearest wins
        tv[0] = 3; tv[1] = 0; tv[2] = 1; dv[0] = 4; dv[1] = 6; dv[2] = 7;
        run_job("tie", 1'b1);
        check("tie.class_const", obs_c, W'(3));
        check("tie.votes_const", obs_v, W'(1));
        check("tie.dist_const", obs_d, W'(4));

        // Illegal labels are skipped, including ones differing only in upper bits
        rand_dists();
        tv[0] = 7; tv[1] = 16'h8001; tv[2] = 1;
        run_job("illegal", 1'b1);
        check("illegal.class_const", obs_c, W'(1));
        check("illegal.votes_const", obs_v, W'(1));
        check("illegal.dist_const", obs_d, dv[2]);

        // No legal label at all
        tv[0] = 4; tv[1] = 5; tv[2] = 6;
        run_job("novote", 1'b1);
        check("novote.flag_const", W'(obs_nv), W'(1));
        check("novote.class_const", obs_c, W'(0));

        // Backpressure: result held, no new accept until consumed
        rand_dists();
        tv[0] = 1; tv[1] = 1; tv[2] = 0;
        run_job("bp", 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp.out_valid", W'(bus.out_valid), W'(1));
            check("bp.in_ready", W'(bus.in_ready), W'(0));
            check("bp.class", bus.class_out, obs_c);
            check("bp.votes", bus.votes_out, obs_v);
            check("bp.dist", bus.dist_out, obs_d);
        end
        ack("bp");
        tv[0] = 0; tv[1] = 3; tv[2] = 3;
        run_job("bp_next", 1'b0);

        // Reset while counting a fresh job
        ack("pre_rst");
        tv[0] = 2; tv[1] = 2; tv[2] = 2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.type_in[i]     = tv[i];
            bus.distance_in[i] = dv[i];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst.busy", W'(bus.in_ready), W'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst.in_ready", W'(bus.in_ready), W'(1));
        check("rst.out_valid", W'(bus.out_valid), W'(0));
        check("rst.class", bus.class_out, W'(0));
        check("rst.votes", bus.votes_out, W'(0));
        check("rst.dist", bus.dist_out, W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.no_result", W'(bus.out_valid), W'(0));
        tv[0] = 0; tv[1] = 0; tv[2] = 1;
        run_job("after_rst", 1'b1);
        check("after_rst.class_const", obs_c, W'(0));
        check("after_rst.votes_const", obs_v, W'(2));

        // Randomized jobs against the reference
        for (int r = 0; r < 25; r++) begin
            rand_dists();
            for (int i = 0; i < N; i++) tv[i] = W'($urandom_range(0, C + 2));
            if (r % 5 == 0) tv[1] = W'($urandom);
            run_job("rand", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
